// File: rtl/tx_stream_scheduler.sv
// Tx stream scheduler: picks OS generator vs. LPIF data path on 128b/130b block
// boundaries, inserting EDS before leaving the data stream and periodic SKP OSes.
module tx_stream_scheduler #(
   parameter int unsigned BLOCK_LEN    = 2,
   parameter int unsigned SKP_INTERVAL = 370,
   parameter int unsigned CNT_W        = 9
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       link_up,
   input  logic       os_req,
   output logic       sel,
   output logic       data_stall,
   output logic       eds_req,
   output logic       skp_req,
   output logic       block_start,
   output logic [1:0] state_o
);

   localparam int unsigned BLK_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLOCK_LEN - 1);
   localparam logic [CNT_W-1:0] SKP_LAST = CNT_W'(SKP_INTERVAL - 1);

   typedef enum logic [1:0] {
      ST_OS   = 2'd0,
      ST_DATA = 2'd1,
      ST_EDS  = 2'd2,
      ST_SKP  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
   logic [CNT_W-1:0] skp_cnt_q, skp_cnt_d;
   logic             skp_pending_q, skp_pending_d;
   logic             sel_q, sel_d;
   logic             data_stall_q, data_stall_d;
   logic             eds_req_q, eds_req_d;
   logic             skp_req_q, skp_req_d;
   logic             block_start_q, block_start_d;
   logic             boundary;

   // State, counters and registered output decode
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_OS;
         blk_cnt_q     <= '0;
         skp_cnt_q     <= '0;
         skp_pending_q <= 1'b0;
         sel_q         <= 1'b0;
         data_stall_q  <= 1'b1;
         eds_req_q     <= 1'b0;
         skp_req_q     <= 1'b0;
         block_start_q <= 1'b1;
      end else begin
         state_q       <= state_d;
         blk_cnt_q     <= blk_cnt_d;
         skp_cnt_q     <= skp_cnt_d;
         skp_pending_q <= skp_pending_d;
         sel_q         <= sel_d;
         data_stall_q  <= data_stall_d;
         eds_req_q     <= eds_req_d;
         skp_req_q     <= skp_req_d;
         block_start_q <= block_start_d;
      end
   end

   // Next-state, SKP scheduling and output decode of the next state
   always_comb begin
      state_d       = state_q;
      skp_cnt_d     = skp_cnt_q;
      skp_pending_d = skp_pending_q;
      boundary      = (blk_cnt_q == BLK_LAST);
      blk_cnt_d     = boundary ? '0 : blk_cnt_q + 1'b1;

      if (boundary) begin
         case (state_q)
            ST_OS:   if (link_up && !os_req) state_d = ST_DATA;
            ST_DATA: if (!link_up || os_req || skp_pending_q) state_d = ST_EDS;
            ST_EDS:  state_d = (skp_pending_q && link_up && !os_req) ? ST_SKP : ST_OS;
            ST_SKP:  state_d = (link_up && !os_req) ? ST_DATA : ST_OS;
            default: state_d = ST_OS;
         endcase

         // Leaving SKP or dropping to OS restarts the interval; entering or
         // staying in the data stream counts one more block (saturating).
         if (state_q == ST_SKP || state_d == ST_OS) begin
            skp_cnt_d     = '0;
            skp_pending_d = 1'b0;
         end else if (state_d == ST_DATA || state_d == ST_EDS) begin
            if (skp_cnt_q != SKP_LAST) skp_cnt_d = skp_cnt_q + 1'b1;
            if (skp_cnt_d == SKP_LAST) skp_pending_d = 1'b1;
         end
      end else if (state_q == ST_OS) begin
         skp_cnt_d     = '0;
         skp_pending_d = 1'b0;
      end

      sel_d         = (state_d == ST_DATA) || (state_d == ST_EDS);
      data_stall_d  = (state_d != ST_DATA);
      eds_req_d     = (state_d == ST_EDS);
      skp_req_d     = (state_d == ST_SKP);
      block_start_d = (blk_cnt_d == '0);
   end

   assign sel         = sel_q;
   assign data_stall  = data_stall_q;
   assign eds_req     = eds_req_q;
   assign skp_req     = skp_req_q;
   assign block_start = block_start_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_tx_stream_scheduler.sv
// Bench for tx_stream_scheduler: block-level behavioural model compared every
// cycle, plus hand-computed expectations at key cycles of each scenario.
module tb_tx_stream_scheduler;

   localparam int BL = 2;
   localparam int SI = 4;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic       link_up = 1'b0;
   logic       os_req  = 1'b0;
   logic       sel, data_stall, eds_req, skp_req, block_start;
   logic [1:0] state_o;

   int n_checks  = 0;
   int n_fail    = 0;
   int cyc       = 0;
   bit cmp_en    = 1'b0;
   bit count_skp = 1'b0;
   int skp_seen  = 0;

   always #5 clk = ~clk;

   tx_stream_scheduler #(
      .BLOCK_LEN   (BL),
      .SKP_INTERVAL(SI),
      .CNT_W       (3)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .link_up    (link_up),
      .os_req     (os_req),
      .sel        (sel),
      .data_stall (data_stall),
      .eds_req    (eds_req),
      .skp_req    (skp_req),
      .block_start(block_start),
      .state_o    (state_o)
   );

   // Model: phase within block, current stream kind, data blocks seen since stream entry
   int m_blk   = 0;
   int m_state = 0;
   int m_blocks = 0;
   int m_nxt   = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_blk    = 0;
         m_state  = 0;
         m_blocks = 0;
      end else if (m_blk != BL - 1) begin
         m_blk = m_blk + 1;
      end else begin
         m_blk = 0;
         case (m_state)
            0: m_nxt = (link_up && !os_req) ? 1 : 0;
            1: m_nxt = (!link_up || os_req || m_blocks >= SI - 1) ? 2 : 1;
            2: m_nxt = (m_blocks >= SI - 1 && link_up && !os_req) ? 3 : 0;
            default: m_nxt = (link_up && !os_req) ? 1 : 0;
         endcase
         if (m_state == 3 || m_nxt == 0) m_blocks = 0;
         else if (m_nxt != 3) m_blocks = m_blocks + 1;
         m_state = m_nxt;
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input int exp);
      n_checks++;
      if (act !== 32'(exp)) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: actual=%0d required=%0d", nm, cyc, act, exp);
      end
   endtask

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (cmp_en) begin
         check("m_sel",         32'(sel),         (m_state == 1 || m_state == 2) ? 1 : 0);
         check("m_data_stall",  32'(data_stall),  (m_state != 1) ? 1 : 0);
         check("m_eds_req",     32'(eds_req),     (m_state == 2) ? 1 : 0);
         check("m_skp_req",     32'(skp_req),     (m_state == 3) ? 1 : 0);
         check("m_block_start", 32'(block_start), (m_blk == 0) ? 1 : 0);
         check("m_state_o",     32'(state_o),     m_state);
         if (count_skp && skp_req === 1'b1) skp_seen++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic goto(input int c);
      while (cyc < c) tick();
   endtask

   task automatic sample(input int c);
      goto(c);
      @(negedge clk);
   endtask

   task automatic expect_state(input string nm, input int st);
      check({nm, "_state"}, 32'(state_o), st);
      check({nm, "_sel"},   32'(sel),     (st == 1 || st == 2) ? 1 : 0);
      check({nm, "_stall"}, 32'(data_stall), (st == 1) ? 0 : 1);
      check({nm, "_eds"},   32'(eds_req), (st == 2) ? 1 : 0);
      check({nm, "_skp"},   32'(skp_req), (st == 3) ? 1 : 0);
   endtask

   // Hold reset with random inputs, then release at the start of cycle 0
   task automatic do_reset(input int ncyc);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      for (int i = 0; i < ncyc; i++) begin
         link_up = 1'($urandom_range(0, 1));
         os_req  = 1'($urandom_range(0, 1));
         @(negedge clk);
         expect_state("rst", 0);
         check("rst_block_start", 32'(block_start), 1);
         @(posedge clk);
         #1;
      end
      link_up = 1'b0;
      os_req  = 1'b0;
      rst_n   = 1'b1;
      cyc     = 0;
   endtask

   initial begin
      @(posedge clk);
      #1;
      cmp_en = 1'b1;

      // Reset, entry and periodic SKP
      do_reset(5);
      link_up = 1'b1;
      sample(1);  expect_state("entry_c1", 0);
      sample(2);  expect_state("entry_c2", 1);
      check("bs_c2", 32'(block_start), 1);
      sample(3);  check("bs_c3", 32'(block_start), 0);
      sample(7);  expect_state("per_c7", 1);
      sample(8);  expect_state("per_c8_eds", 2);
      sample(9);  expect_state("per_c9_eds", 2);
      sample(10); expect_state("per_c10_skp", 3);
      sample(11); expect_state("per_c11_skp", 3);
      sample(12); expect_state("per_c12", 1);
      sample(19); expect_state("per_c19", 1);
      sample(20); expect_state("per_c20_eds", 2);
      sample(22); expect_state("per_c22_skp", 3);

      // os_req: mid-block pulse ignored, held request exits via EDS
      do_reset(2);
      link_up = 1'b1;
      goto(4);
      os_req = 1'b1;
      #2;
      os_req = 1'b0;
      sample(4);  expect_state("osr_c4", 1);
      goto(5);
      os_req = 1'b1;
      sample(5);  expect_state("osr_c5", 1);
      sample(6);  expect_state("osr_c6_eds", 2);
      sample(8);  expect_state("osr_c8_os", 0);
      sample(9);  expect_state("osr_c9_os", 0);
      goto(10);
      os_req = 1'b0;
      sample(11); expect_state("osr_c11", 0);
      sample(12); expect_state("osr_c12", 1);

      // os_req drops during EDS with SKP pending: SKP then DATA
      do_reset(2);
      link_up = 1'b1;
      goto(5);
      os_req = 1'b1;
      goto(6);
      os_req = 1'b0;
      sample(6);  expect_state("eds2skp_c6", 2);
      sample(8);  expect_state("eds2skp_c8", 3);
      sample(10); expect_state("eds2skp_c10", 1);

      // Link drop on the boundary that sets SKP pending: SKP discarded
      do_reset(2);
      link_up   = 1'b1;
      skp_seen  = 0;
      count_skp = 1'b1;
      goto(5);
      link_up = 1'b0;
      sample(6);  expect_state("cfl_c6", 2);
      sample(8);  expect_state("cfl_c8", 0);
      goto(10);
      link_up = 1'b1;
      sample(12); expect_state("cfl_c12", 1);
      sample(17); expect_state("cfl_c17", 1);
      sample(18); expect_state("cfl_c18_eds", 2);
      sample(19);
      count_skp = 1'b0;
      check("cfl_no_skp", 32'(skp_seen), 0);
      sample(20); expect_state("cfl_c20_skp", 3);

      // Async reset in the middle of a SKP block
      do_reset(2);
      link_up = 1'b1;
      sample(10); expect_state("ar_c10", 3);
      #1;
      rst_n = 1'b0;
      #1;
      expect_state("ar_immediate", 0);
      do_reset(2);
      link_up = 1'b1;
      sample(1);  expect_state("ar2_c1", 0);
      sample(2);  expect_state("ar2_c2", 1);
      sample(8);  expect_state("ar2_c8", 2);
      sample(10); expect_state("ar2_c10", 3);
      sample(12); expect_state("ar2_c12", 1);

      cmp_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tx_stream_scheduler.md
Name: tx_stream_scheduler

Overview:
- Controls the Tx stream select between the ordered-set generator and the LPIF Tx data path (TLP/DLLP), one level above the Tx MUX.
- Switches only on 128b/130b block boundaries.
- Inserts an EDS block before leaving the data stream, and schedules periodic SKP ordered sets during data transfer.
- Drives the MUX select and the data-path stall, and issues EDS/SKP requests.

Parameters:
- BLOCK_LEN, 2, clock cycles per 130-bit block on the 512-bit datapath (≥1).
- SKP_INTERVAL, 370, data-stream blocks between SKP ordered sets (≥2).
- CNT_W, 9, width of the SKP block counter; must satisfy 2^CNT_W > SKP_INTERVAL.

Ports:
- clk  in  1  Tx PHY clock.
- rst_n  in  1  asynchronous active-low reset.
- link_up  in  1  Tx LTSSM is in L0; data stream permitted.
- os_req  in  1  Tx LTSSM requests OS transmission (training, electrical idle, etc.); level.
- sel  out  1  MUX select: 1 = data path, 0 = OS generator.
- data_stall  out  1  1 = LPIF Tx data path must hold its data.
- eds_req  out  1  data path must emit the EDS token in the current block.
- skp_req  out  1  OS generator must emit a SKP OS in the current block.
- block_start  out  1  high on the first cycle of each block.
- state_o  out  2  current state: 0 OS, 1 DATA, 2 EDS, 3 SKP.

Behaviour:
- Reset (async, rst_n=0):
  - state=OS, blk_cnt=0, skp_cnt=0, skp_pending=0.
  - sel=0, data_stall=1, eds_req=0, skp_req=0, block_start=1, state_o=0.
- Block counter:
  - blk_cnt counts 0..BLOCK_LEN-1 every cycle and wraps.
  - A boundary is the cycle with blk_cnt==BLOCK_LEN-1.
  - block_start = (blk_cnt==0).
- State register updates only on a boundary edge. All outputs are a registered decode of state, so outputs change on the first cycle of the new block. Decisions use input values sampled on the boundary cycle; mid-block input changes have no effect until the next boundary.
- Output decode:
  - OS: sel=0, data_stall=1.
  - DATA: sel=1, data_stall=0.
  - EDS: sel=1, data_stall=1, eds_req=1.
  - SKP: sel=0, data_stall=1, skp_req=1.
  - All other outputs are 0 in each state.
- Transitions, evaluated at a boundary:
  - OS: link_up && !os_req → DATA; else stay in OS.
  - DATA: (!link_up || os_req || skp_pending) → EDS; else stay in DATA.
  - EDS (exactly one block): skp_pending && link_up && !os_req → SKP; else → OS.
  - SKP (exactly one block): link_up && !os_req → DATA; else → OS.
- Exit priority: !link_up > os_req > skp_pending. A link drop or os_req always wins over a pending SKP, and the SKP is discarded.
- SKP scheduling:
  - skp_cnt increments at each boundary while in DATA or EDS.
  - When the increment reaches SKP_INTERVAL-1, skp_pending is set and skp_cnt holds (saturates, no wrap).
  - skp_cnt and skp_pending are cleared on the boundary leaving SKP, and whenever the state is OS.
- Simultaneous events:
  - skp_pending set on the same boundary as os_req → EDS, then OS; the pending SKP is cleared.
  - os_req deasserting in the EDS block while skp_pending → SKP, then DATA.
- Reset asserted mid-block: immediate defaults; after release, blk_cnt restarts at 0, so the first boundary is cycle BLOCK_LEN-1.
- There is never a direct DATA→OS or DATA→SKP transition. sel never changes except at block_start.

Test Plan (BLOCK_LEN=2, SKP_INTERVAL=4; cycle 0 = first cycle after rst_n release):
- Reset: hold rst_n=0 with random inputs → sel=0, data_stall=1, eds_req=0, skp_req=0, state_o=0 throughout.
- Entry: link_up=1, os_req=0 from cycle 0 → sel=1, data_stall=0, state_o=1 from cycle 2.
- Periodic SKP, continuing from entry:
  - DATA during cycles 2–7.
  - EDS during cycles 8–9: eds_req=1, sel=1, data_stall=1.
  - SKP during cycles 10–11: skp_req=1, sel=0.
  - DATA again from cycle 12.
  - Next EDS at cycle 20.
- os_req: pulse os_req=1 on cycle 4 (mid-block, deasserted before cycle 5) → no effect, stays in DATA. os_req=1 held from cycle 5 → EDS in cycles 6–7, then OS (sel=0, data_stall=1) from cycle 8 for as long as os_req=1. Release os_req at cycle 10 → DATA from cycle 12.
- Conflict: link_up→0 on the boundary where skp_pending is set → EDS, then OS; skp_req is never asserted. Re-raise link_up → DATA, and the first SKP occurs only after a further 4 blocks.
- Async reset: assert rst_n=0 mid-SKP block (cycle 10.5) → skp_req=0, sel=0 within the same cycle. After release, the entry sequence repeats exactly.
